// File: rtl/hamming_test_sequencer.sv
// Self-test sequencer for a Hamming(7,4) encoder/decoder pair: sweeps all 16 data words and counts pass/fail.
// Optional feature macro: HAMMING_SEQ_INJECT_EN (single-bit error injection at position w mod 8).
module hamming_test_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_enc_data,
    input  logic [6:0] i_enc_codeword,
    output logic [6:0] o_dec_codeword,
    output logic       o_dec_valid,
    input  logic       i_dec_ready,
    input  logic       i_dec_resp_valid,
    input  logic [3:0] i_dec_data,
    input  logic [2:0] i_dec_syndrome,
    output logic [4:0] o_pass_count,
    output logic [4:0] o_fail_count,
    output logic       o_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_SEND,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [4:0] CNT_MAX  = 5'd16;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_word;
    logic [2:0] r_pos;
    logic [6:0] r_codeword;
    logic [3:0] r_resp_data;
    logic [2:0] r_resp_syn;
    logic [7:0] r_tcnt;
    logic [4:0] r_pass;
    logic [4:0] r_fail;
    logic       r_timeout_err;

    logic [2:0] w_inj_pos;
    logic [6:0] w_flip_mask;
    logic       w_handshake;
    logic       w_timeout;
    logic       w_pass;
    logic       w_last_word;

`ifdef HAMMING_SEQ_INJECT_EN
    assign w_inj_pos = r_word[2:0];
`else
    assign w_inj_pos = 3'd0;
`endif

    // Position 0 means "no error"; otherwise flip codeword bit pos-1.
    always_comb begin
        w_flip_mask = '0;
        if (w_inj_pos != 3'd0) begin
            w_flip_mask[w_inj_pos - 3'd1] = 1'b1;
        end
    end

    assign w_handshake = (r_state == S_SEND) && i_dec_ready;
    assign w_timeout   = (r_state == S_WAIT) && !i_dec_resp_valid && (r_tcnt == TMO_LAST);
    assign w_pass      = (r_resp_data == r_word) && (r_resp_syn == r_pos);
    assign w_last_word = (r_word == 4'd15);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_LOAD;
            S_LOAD:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SEND;
            S_SEND:    if (w_handshake) w_next = S_WAIT;
            S_WAIT: begin
                if (i_dec_resp_valid) begin
                    w_next = S_CHECK;
                end else if (w_timeout) begin
                    w_next = w_last_word ? S_DONE : S_LOAD;
                end
            end
            S_CHECK:   w_next = w_last_word ? S_DONE : S_LOAD;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_word        <= '0;
            r_pos         <= '0;
            r_codeword    <= '0;
            r_resp_data   <= '0;
            r_resp_syn    <= '0;
            r_tcnt        <= '0;
            r_pass        <= '0;
            r_fail        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_word        <= '0;
                        r_pass        <= '0;
                        r_fail        <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    r_codeword <= i_enc_codeword ^ w_flip_mask;
                    r_pos      <= w_inj_pos;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_tcnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_dec_resp_valid) begin
                        r_resp_data <= i_dec_data;
                        r_resp_syn  <= i_dec_syndrome;
                    end else if (w_timeout) begin
                        // A timed-out word counts as a failure and skips CHECK.
                        if (r_fail != CNT_MAX) r_fail <= r_fail + 5'd1;
                        r_timeout_err <= 1'b1;
                        if (!w_last_word) r_word <= r_word + 4'd1;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (w_pass) begin
                        if (r_pass != CNT_MAX) r_pass <= r_pass + 5'd1;
                    end else begin
                        if (r_fail != CNT_MAX) r_fail <= r_fail + 5'd1;
                    end
                    if (!w_last_word) r_word <= r_word + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_dec_valid    = (r_state == S_SEND);
    assign o_enc_data     = r_word;
    assign o_dec_codeword = r_codeword;
    assign o_pass_count   = r_pass;
    assign o_fail_count   = r_fail;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_hamming_test_sequencer.sv
// Scoreboard bench for hamming_test_sequencer with a behavioural encoder and a configurable decoder responder.
// Honours HAMMING_SEQ_INJECT_EN the same way as the design build.
module tb_hamming_test_sequencer;

    localparam int TIMEOUT = 15;
`ifdef HAMMING_SEQ_INJECT_EN
    localparam int RAW_PASS = 2;
`else
    localparam int RAW_PASS = 16;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] encData;
    logic [6:0] encCodeword;
    logic [6:0] decCodeword;
    logic       decValid;
    logic       decReady = 1'b1;
    logic       decRespValid = 1'b0;
    logic [3:0] decData = '0;
    logic [2:0] decSyndrome = '0;
    logic [4:0] passCount;
    logic [4:0] failCount;
    logic       timeoutErr;

    typedef struct {
        int passN;
        int failN;
        int toN;
    } sum_t;

    // Hand-computed Hamming(7,4) codewords, bit k-1 = position k.
    logic [6:0] cwTable [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                 7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    logic [6:0] expCwQ [$];
    sum_t       sumQ [$];

    int checks = 0;
    int passes = 0;
    int stallWord = -1;
    int stallLeft = 0;
    int dropWord = -1;
    bit rawMode = 1'b0;
    bit respPending = 1'b0;
    logic [6:0] pendingCw = '0;
    int pendingWord = 0;

    always #5 clk = ~clk;

    hamming_test_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_start          (start),
        .o_busy           (busy),
        .o_done           (done),
        .o_enc_data       (encData),
        .i_enc_codeword   (encCodeword),
        .o_dec_codeword   (decCodeword),
        .o_dec_valid      (decValid),
        .i_dec_ready      (decReady),
        .i_dec_resp_valid (decRespValid),
        .i_dec_data       (decData),
        .i_dec_syndrome   (decSyndrome),
        .o_pass_count     (passCount),
        .o_fail_count     (failCount),
        .o_timeout_err    (timeoutErr)
    );

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    assign encCodeword = encode(encData);

    // Returns {syndrome, corrected data}.
    function automatic logic [6:0] decode(input logic [6:0] cw);
        logic [2:0] syn = 3'd0;
        logic [6:0] c;
        for (int k = 1; k <= 7; k++) begin
            if (cw[k-1]) syn = syn ^ 3'(k);
        end
        c = cw;
        if (syn != 3'd0) c[syn - 3'd1] = ~c[syn - 3'd1];
        return {syn, c[6], c[5], c[4], c[2]};
    endfunction

    function automatic logic [6:0] injMask(input int w);
        logic [6:0] m = '0;
        int p = w % 8;
`ifdef HAMMING_SEQ_INJECT_EN
        if (p != 0) m[p-1] = 1'b1;
`endif
        return m;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // dec_ready is decided just after each rising edge so it is stable for the whole cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (decValid && stallWord == int'(encData) && stallLeft > 0) begin
                decReady = 1'b0;
                stallLeft--;
            end else begin
                decReady = 1'b1;
            end
        end
    end

    // Decoder model: answers one cycle after the handshake, or never for dropWord.
    initial begin
        logic [6:0] r;
        forever begin
            @(negedge clk);
            decRespValid = 1'b0;
            if (!reset_n) begin
                respPending = 1'b0;
            end else begin
                if (respPending) begin
                    respPending = 1'b0;
                    if (pendingWord != dropWord) begin
                        r = rawMode ? {3'd0, pendingCw[6], pendingCw[5], pendingCw[4], pendingCw[2]}
                                    : decode(pendingCw);
                        decSyndrome  = r[6:4];
                        decData      = r[3:0];
                        decRespValid = 1'b1;
                    end
                end
                if (decValid && decReady) begin
                    respPending = 1'b1;
                    pendingCw   = decCodeword;
                    pendingWord = int'(encData);
                end
            end
        end
    end

    // Monitor: checks every presented codeword and the end-of-sweep counts against the scoreboard.
    initial begin
        sum_t s;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (decValid) begin
                    if (expCwQ.size() == 0) begin
                        checkOutput("unexpected_dec_valid", 1, 0);
                    end else begin
                        checkOutput($sformatf("dec_codeword_w%0d", encData), decCodeword, expCwQ[0]);
                        if (decReady) void'(expCwQ.pop_front());
                    end
                end
                if (done) begin
                    if (sumQ.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        s = sumQ.pop_front();
                        checkOutput("pass_count", passCount, s.passN);
                        checkOutput("fail_count", failCount, s.failN);
                        checkOutput("timeout_err", timeoutErr, s.toN);
                    end
                end
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_enc_data"}, encData, 0);
        checkOutput({tag, "_dec_valid"}, decValid, 0);
        checkOutput({tag, "_dec_codeword"}, decCodeword, 0);
        checkOutput({tag, "_pass_count"}, passCount, 0);
        checkOutput({tag, "_fail_count"}, failCount, 0);
        checkOutput({tag, "_timeout_err"}, timeoutErr, 0);
    endtask

    task automatic pushCodewords();
        for (int w = 0; w < 16; w++) expCwQ.push_back(cwTable[w] ^ injMask(w));
    endtask

    task automatic applyStimulus(input int expPass, input int expFail, input int expTo,
                                 input int expCycles, input bit pokeStart);
        int cnt = 0;
        int guard = 0;
        bit seenDone = 1'b0;
        pushCodewords();
        sumQ.push_back('{expPass, expFail, expTo});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do begin
            if (busy) cnt++;
            if (done) begin
                seenDone = 1'b1;
            end else begin
                @(negedge clk);
                guard++;
                start = pokeStart && (cnt >= 20) && (cnt < 22);
            end
        end while (!seenDone && guard < 600);
        start = 1'b0;
        checkOutput("sweep_done_seen", seenDone, 1);
        if (expCycles != 0) checkOutput("sweep_cycles", cnt, expCycles);
        @(negedge clk);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("done_single_cycle", done, 0);
        checkOutput("pass_count_hold", passCount, expPass);
        checkOutput("scoreboard_drained", expCwQ.size(), 0);
    endtask

    initial begin
        bit found;
        int guard;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        #2 reset_n = 1'b1;

        applyStimulus(16, 0, 0, 81, 1'b1);

        rawMode = 1'b1;
        applyStimulus(RAW_PASS, 16 - RAW_PASS, 0, 81, 1'b0);
        rawMode = 1'b0;

        stallWord = 3;
        stallLeft = 5;
        applyStimulus(16, 0, 0, 86, 1'b0);
        checkOutput("stall_consumed", stallLeft, 0);
        stallWord = -1;

        dropWord = 7;
        applyStimulus(15, 1, 1, 81 + TIMEOUT - 2, 1'b0);
        dropWord = -1;

        pushCodewords();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 300) begin
            if (decValid && encData == 4'd9) found = 1'b1;
            else begin
                @(negedge clk);
                guard++;
            end
        end
        checkOutput("reached_word9_send", found, 1);
        #2 reset_n = 1'b0;
        expCwQ.delete();
        #1 checkResetValues("midsweep_reset");
        repeat (2) @(negedge clk);
        checkResetValues("held_reset");
        #2 reset_n = 1'b1;

        applyStimulus(16, 0, 0, 81, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
